// File: rtl/rpm_pkg.sv
// Shared types and defaults for the recursive-property monitor.
// Cover counters are built only when RPM_COVER_EN is defined.
package rpm_pkg;

  typedef enum logic {ALW_IDLE, ALW_ARMED} alw_state_t;
  typedef enum logic {WU_IDLE, WU_ACTIVE} wu_state_t;

  localparam int RPM_CNT_W = 8;

endpackage

// File: rtl/rpm_sat_cnt.sv
// Saturating up-counter with synchronous reset and clear.
// Clear outranks increment, so an event on the clear edge is dropped.
module rpm_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/recursive_prop_monitor.sv
// Run-time monitor for always-after-trigger, weak-until-after-trigger and
// two-phase obligations. RPM_COVER_EN adds three cover counter ports.
module recursive_prop_monitor
  import rpm_pkg::*;
#(
  parameter int CNT_W = RPM_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             s,
  input  logic             p,
  input  logic             q,
  input  logic             s1,
  input  logic             s2,
  input  logic             phase1_prop,
  input  logic             phase2_prop,
  output logic             fail_alw,
  output logic             fail_wu,
  output logic             fail_ph,
  output logic             sticky_alw,
  output logic             sticky_wu,
  output logic             sticky_ph,
  output logic [CNT_W-1:0] cnt_alw,
  output logic [CNT_W-1:0] cnt_wu,
  output logic [CNT_W-1:0] cnt_ph
`ifdef RPM_COVER_EN
  ,
  output logic [CNT_W-1:0] cov_alw_trig,
  output logic [CNT_W-1:0] cov_wu_dis,
  output logic [CNT_W-1:0] cov_ph_chain
`endif
);

  alw_state_t alw_state_reg;
  wu_state_t  wu_state_reg;
  logic       pend2_reg;
  logic       pend2_next;

  logic       fail_alw_reg, fail_wu_reg, fail_ph_reg;
  logic       sticky_alw_reg, sticky_wu_reg, sticky_ph_reg;

  logic       alw_fail_now, wu_fail_now, wu_dis_now, ph_fail_now;

  // Failure conditions evaluated from current state and sampled operands.
  assign alw_fail_now = (alw_state_reg == ALW_ARMED) && !p;
  assign wu_dis_now   = (wu_state_reg == WU_ACTIVE) && q;
  assign wu_fail_now  = (wu_state_reg == WU_ACTIVE) && !q && !p;
  assign ph_fail_now  = (s1 && !phase1_prop) || (pend2_reg && s2 && !phase2_prop);
  assign pend2_next   = s1 && phase1_prop;

  always_ff @(posedge clk) begin
    if (rst) begin
      alw_state_reg  <= ALW_IDLE;
      wu_state_reg   <= WU_IDLE;
      pend2_reg      <= 1'b0;
      fail_alw_reg   <= 1'b0;
      fail_wu_reg    <= 1'b0;
      fail_ph_reg    <= 1'b0;
      sticky_alw_reg <= 1'b0;
      sticky_wu_reg  <= 1'b0;
      sticky_ph_reg  <= 1'b0;
    end else begin
      case (alw_state_reg)
        ALW_IDLE:  if (s) alw_state_reg <= ALW_ARMED;
        ALW_ARMED: if (!p) alw_state_reg <= s ? ALW_ARMED : ALW_IDLE;
        default:   alw_state_reg <= ALW_IDLE;
      endcase

      // q outranks p; a discharge or failure may re-arm on the same edge.
      case (wu_state_reg)
        WU_IDLE:   if (s) wu_state_reg <= WU_ACTIVE;
        WU_ACTIVE: if (q || !p) wu_state_reg <= s ? WU_ACTIVE : WU_IDLE;
        default:   wu_state_reg <= WU_IDLE;
      endcase

      pend2_reg    <= pend2_next;
      fail_alw_reg <= alw_fail_now;
      fail_wu_reg  <= wu_fail_now;
      fail_ph_reg  <= ph_fail_now;

      if (clr) begin
        sticky_alw_reg <= 1'b0;
        sticky_wu_reg  <= 1'b0;
        sticky_ph_reg  <= 1'b0;
      end else begin
        sticky_alw_reg <= sticky_alw_reg | alw_fail_now;
        sticky_wu_reg  <= sticky_wu_reg  | wu_fail_now;
        sticky_ph_reg  <= sticky_ph_reg  | ph_fail_now;
      end
    end
  end

  assign fail_alw   = fail_alw_reg;
  assign fail_wu    = fail_wu_reg;
  assign fail_ph    = fail_ph_reg;
  assign sticky_alw = sticky_alw_reg;
  assign sticky_wu  = sticky_wu_reg;
  assign sticky_ph  = sticky_ph_reg;

  logic [2:0]       viol_inc;
  logic [CNT_W-1:0] viol_cnt [3];

  assign viol_inc = {ph_fail_now, wu_fail_now, alw_fail_now};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_viol_cnt
      rpm_sat_cnt #(.W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (viol_inc[gi]),
        .cnt (viol_cnt[gi])
      );
    end
  endgenerate

  assign cnt_alw = viol_cnt[0];
  assign cnt_wu  = viol_cnt[1];
  assign cnt_ph  = viol_cnt[2];

`ifdef RPM_COVER_EN
  logic [2:0]       cov_inc;
  logic [CNT_W-1:0] cov_cnt [3];

  assign cov_inc = {pend2_next && !pend2_reg,
                    wu_dis_now,
                    (alw_state_reg == ALW_IDLE) && s};

  generate
    for (gi = 0; gi < 3; gi++) begin : g_cov_cnt
      rpm_sat_cnt #(.W(CNT_W)) u_cov (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (cov_inc[gi]),
        .cnt (cov_cnt[gi])
      );
    end
  endgenerate

  assign cov_alw_trig = cov_cnt[0];
  assign cov_wu_dis   = cov_cnt[1];
  assign cov_ph_chain = cov_cnt[2];
`else
  // Discharges only feed the cover counters; keep the net referenced.
  logic unused_wu_dis;
  assign unused_wu_dis = wu_dis_now;
`endif

endmodule
